// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared opcode, funct3, writeback-select and MEM FSM types for the RV32I memory stage
package rv32i_pkg;

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [31:0] NOP      = 32'h00000013;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MEM = 2'b01,
        SRC_PC4 = 2'b10
    } src_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// rtl/rv32i_lsu_align.sv - combinational store lane steering, load extraction/extension and misalign detection
module rv32i_lsu_align
    import rv32i_pkg::*;
(
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_be        = 4'b1111;
        o_wdata     = i_rs2;
        o_load_data = i_rdata;
        o_misalign  = 1'b0;
        if (i_is_store) begin
            case (i_funct3)
                F3_B: begin
                    o_be    = 4'b0001 << i_off;
                    o_wdata = {4{i_rs2[7:0]}};
                end
                F3_H: begin
                    o_be       = i_off[1] ? 4'b1100 : 4'b0011;
                    o_wdata    = {2{i_rs2[15:0]}};
                    o_misalign = i_off[0];
                end
                F3_W:    o_misalign = |i_off;
                default: o_misalign = 1'b1;
            endcase
        end else if (i_is_load) begin
            case (i_funct3)
                F3_B:  o_load_data = sext8(w_byte);
                F3_BU: o_load_data = {24'd0, w_byte};
                F3_H: begin
                    o_load_data = sext16(w_half);
                    o_misalign  = i_off[0];
                end
                F3_HU: begin
                    o_load_data = {16'd0, w_half};
                    o_misalign  = i_off[0];
                end
                F3_W: begin
                    o_load_data = i_rdata;
                    o_misalign  = |i_off;
                end
                default: o_misalign = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_mem_stage.sv
// rtl/rv32i_mem_stage.sv - RV32I memory-access stage with req/ready data port, stall FSM and MEM/WB register
// Optional access timeout enabled by defining RV32I_MEM_TIMEOUT_EN.
module rv32i_mem_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_IW         = NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_reg_in,
    input  logic [1:0]  src_sel_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_out,
    output logic [31:0] wb_data_out,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_en_out,
    output logic        misalign_out,
    output logic        mem_err_out,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data
);

    mem_state_t  r_state;
    logic [31:0] r_wb_data;
    logic [31:0] r_iw;
    logic [31:0] r_pc;
    logic [4:0]  r_wb_reg;
    logic        r_wb_en;
    logic        r_misalign;
    logic        r_mem_err;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_access;
    logic        w_timeout;
    logic        w_req;
    logic        w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;
    logic        w_unused_iw;

    assign w_is_load   = (iw_in[6:0] == OP_LOAD);
    assign w_is_store  = (iw_in[6:0] == OP_STORE);
    assign w_unused_iw = ^{iw_in[31:15], iw_in[11:7]};

    rv32i_lsu_align u_align (
        .i_is_load   (w_is_load),
        .i_is_store  (w_is_store),
        .i_funct3    (iw_in[14:12]),
        .i_off       (alu_in[1:0]),
        .i_rs2       (rs2_data_in),
        .i_rdata     (dmem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_load_data),
        .o_misalign  (w_misalign)
    );

    // Misaligned or undefined accesses never reach memory; they only raise the flag.
    assign w_access = (w_is_load | w_is_store) & ~w_misalign;

`ifdef RV32I_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_cnt;
    assign w_timeout = (r_state == WAIT) & ~dmem_ready
                     & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    // In WAIT the upstream holds its inputs, so the same decode drives the request.
    assign w_req      = ~reset & ~w_timeout & (((r_state == IDLE) & w_access) | (r_state == WAIT));
    assign w_stall    = w_req & ~dmem_ready;
    assign dmem_req   = w_req;
    assign stall_out  = w_stall;
    assign dmem_we    = w_req & w_is_store;
    assign dmem_be    = w_be;
    assign dmem_addr  = {alu_in[31:2], 2'b00};
    assign dmem_wdata = w_wdata;

    always_comb begin
        w_wb_data = alu_in;
        case (src_sel_in)
            SRC_MEM: w_wb_data = w_load_data;
            SRC_PC4: w_wb_data = pc_in + 32'd4;
            default: w_wb_data = alu_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wb_data  <= 32'd0;
            r_iw       <= NOP_IW;
            r_pc       <= 32'd0;
            r_wb_reg   <= 5'd0;
            r_wb_en    <= 1'b0;
            r_misalign <= 1'b0;
            r_mem_err  <= 1'b0;
`ifdef RV32I_MEM_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_misalign <= 1'b0;
            r_mem_err  <= 1'b0;

            if (r_state == IDLE) begin
                if (w_stall) r_state <= WAIT;
            end else begin
                if (dmem_ready || w_timeout) r_state <= IDLE;
            end

            if (w_stall) begin
                r_iw      <= NOP_IW;
                r_pc      <= 32'd0;
                r_wb_data <= 32'd0;
                r_wb_reg  <= 5'd0;
                r_wb_en   <= 1'b0;
            end else if (w_timeout) begin
                r_iw      <= iw_in;
                r_pc      <= pc_in;
                r_wb_data <= 32'd0;
                r_wb_reg  <= 5'd0;
                r_wb_en   <= 1'b0;
                r_mem_err <= 1'b1;
            end else begin
                r_iw       <= iw_in;
                r_pc       <= pc_in;
                r_wb_data  <= w_wb_data;
                r_wb_reg   <= wb_reg_in;
                r_wb_en    <= wb_en_in & ~w_misalign;
                r_misalign <= w_misalign;
            end

`ifdef RV32I_MEM_TIMEOUT_EN
            r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
`endif
        end
    end

    assign wb_data_out   = r_wb_data;
    assign iw_out        = r_iw;
    assign pc_out        = r_pc;
    assign wb_reg_out    = r_wb_reg;
    assign wb_en_out     = r_wb_en;
    assign misalign_out  = r_misalign;
    assign mem_err_out   = r_mem_err;
    assign df_mem_enable = r_wb_en;
    assign df_mem_reg    = r_wb_reg;
    assign df_mem_data   = r_wb_data;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// tb/tb_rv32i_mem_stage.sv - scoreboard bench for rv32i_mem_stage with a variable-latency memory responder
module tb_rv32i_mem_stage;

    localparam logic [31:0] NOP_IW = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0, iw_in = NOP_IW, alu_in = '0, rs2_data_in = '0;
    logic        wb_en_in = 1'b0;
    logic [4:0]  wb_reg_in = '0;
    logic [1:0]  src_sel_in = '0;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_out;
    logic [31:0] wb_data_out, iw_out, pc_out, df_mem_data;
    logic [4:0]  wb_reg_out, df_mem_reg;
    logic        wb_en_out, misalign_out, mem_err_out, df_mem_enable;

    always #5 clk = ~clk;

    rv32i_mem_stage #(.TIMEOUT_CYCLES(4), .NOP_IW(NOP_IW)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in),
        .rs2_data_in(rs2_data_in), .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in),
        .src_sel_in(src_sel_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .stall_out(stall_out), .wb_data_out(wb_data_out),
        .iw_out(iw_out), .pc_out(pc_out), .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out),
        .misalign_out(misalign_out), .mem_err_out(mem_err_out), .df_mem_enable(df_mem_enable),
        .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
    );

    // Memory responder: ready after 'lat' waiting cycles of a continuous request.
    int          lat = 0;
    int          wcnt = 0;
    logic [31:0] mem_word = '0;
    assign dmem_ready = dmem_req && (wcnt >= lat);
    assign dmem_rdata = mem_word;
    always @(posedge clk) begin
        if (!dmem_req || dmem_ready) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wb_en;
        logic        mis;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && iw_out != NOP_IW) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output_iw", iw_out, NOP_IW);
            end else begin
                mon_e = sb_q.pop_front();
                check("pc_out", pc_out, mon_e.pc);
                if (mon_e.chk_data) begin
                    check("wb_data_out", wb_data_out, mon_e.data);
                    check("df_mem_data", df_mem_data, mon_e.data);
                end
                check("ctrl{rd,en,mis,err}", {24'd0, wb_reg_out, wb_en_out, misalign_out, mem_err_out},
                      {24'd0, mon_e.rd, mon_e.wb_en, mon_e.mis, mon_e.err});
                check("df{en,reg}", {26'd0, df_mem_enable, df_mem_reg}, {26'd0, mon_e.wb_en, mon_e.rd});
            end
        end
    end

    task automatic set_idle();
        pc_in = '0; iw_in = NOP_IW; alu_in = '0; rs2_data_in = '0;
        wb_en_in = 1'b0; wb_reg_in = '0; src_sel_in = 2'b00;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic wben, input logic [4:0] rd,
                         input logic [1:0] sel, input int latency, input logic [31:0] rdata,
                         input int exp_stalls, input logic exp_req, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic exp_we,
                         input logic [31:0] exp_data, input logic exp_wben, input logic exp_mis,
                         input logic exp_err, input logic chk_data);
        exp_t e;
        int   cyc;
        int   stalls;
        bit   done;
        lat = latency; mem_word = rdata;
        pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2;
        wb_en_in = wben; wb_reg_in = rd; src_sel_in = sel;
        e.pc = pc; e.data = exp_data; e.rd = exp_err ? 5'd0 : rd; e.wb_en = exp_wben;
        e.mis = exp_mis; e.err = exp_err; e.chk_data = chk_data;
        sb_q.push_back(e);
        cyc = 0; stalls = 0; done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("dmem_req", dmem_req, exp_req);
                if (exp_req) begin
                    check("dmem_addr", dmem_addr, {alu[31:2], 2'b00});
                    check("dmem_be", dmem_be, exp_be);
                    check("dmem_we", dmem_we, exp_we);
                    if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end else begin
                check("bubble_iw", iw_out, NOP_IW);
                check("bubble_wb_en", wb_en_out, 1'b0);
            end
            if (stall_out) stalls++;
            else           done = 1;
            cyc++;
            @(posedge clk); #1;
        end
        set_idle();
        check("stall_cycles", stalls, exp_stalls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Aligned load presented during reset: request and stall must stay gated.
        lat = 0;
        iw_in = 32'h0000A383; alu_in = 32'h100; src_sel_in = 2'b01; wb_en_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_iw_out", iw_out, NOP_IW);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_wb_data", wb_data_out, 32'd0);
        check("rst_flags{en,mis,err}", {wb_en_out, misalign_out, mem_err_out}, 3'b000);
        check("rst_req_gate", dmem_req, 1'b0);
        check("rst_stall_gate", stall_out, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle();
        @(posedge clk); #1;

        //    pc      iw            alu         rs2         en rd sel   lat rdata        st req be       wdata        we data         en mis err chk
        issue(32'h10, 32'h002082B3, 32'h1234,   32'h0,      1, 5, 2'b00, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h1234,     1, 0, 0, 1);
        issue(32'h14, 32'h00008303, 32'h103,    32'h0,      1, 6, 2'b01, 0, 32'h80FF0000, 0, 1, 4'b1111, 32'h0,        0, 32'hFFFFFF80, 1, 0, 0, 1);
        issue(32'h18, 32'h0000C303, 32'h103,    32'h0,      1, 6, 2'b01, 0, 32'h80FF0000, 0, 1, 4'b1111, 32'h0,        0, 32'h00000080, 1, 0, 0, 1);
        issue(32'h1C, 32'h00209023, 32'h202,    32'hABCD1234, 0, 0, 2'b00, 0, 32'h0,      0, 1, 4'b1100, 32'h12341234, 1, 32'h202,      0, 0, 0, 1);
        issue(32'h20, 32'h0000A383, 32'h300,    32'h0,      1, 7, 2'b01, 3, 32'hDEADBEEF, 3, 1, 4'b1111, 32'h0,        0, 32'hDEADBEEF, 1, 0, 0, 1);
        issue(32'h24, 32'h0000A383, 32'h101,    32'h0,      1, 7, 2'b01, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        0, 1, 0, 0);
        issue(32'h40, 32'h008000EF, 32'h48,     32'h0,      1, 1, 2'b10, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h44,       1, 0, 0, 1);
        issue(32'h44, 32'h00208023, 32'h207,    32'hA5,     0, 0, 2'b00, 0, 32'h0,        0, 1, 4'b1000, 32'hA5A5A5A5, 1, 32'h207,      0, 0, 0, 1);
        issue(32'h48, 32'h0020A023, 32'h20C,    32'h11223344, 0, 0, 2'b00, 1, 32'h0,      1, 1, 4'b1111, 32'h11223344, 1, 32'h20C,      0, 0, 0, 1);
        issue(32'h4C, 32'h00009303, 32'h102,    32'h0,      1, 9, 2'b01, 2, 32'h80017FFF, 2, 1, 4'b1111, 32'h0,        0, 32'hFFFF8001, 1, 0, 0, 1);
        issue(32'h50, 32'h0000D303, 32'h102,    32'h0,      1, 9, 2'b01, 1, 32'h80017FFF, 1, 1, 4'b1111, 32'h0,        0, 32'h00008001, 1, 0, 0, 1);
        issue(32'h54, 32'h00209023, 32'h201,    32'h5555,   0, 0, 2'b00, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        0, 1, 0, 0);
        issue(32'h58, 32'h0000B303, 32'h100,    32'h0,      1, 6, 2'b01, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0,        0, 1, 0, 0);
        issue(32'h5C, 32'h00008303, 32'h104,    32'h0,      1, 6, 2'b01, 0, 32'h0000007F, 0, 1, 4'b1111, 32'h0,        0, 32'h0000007F, 1, 0, 0, 1);
        issue(32'h60, 32'h0000D303, 32'h108,    32'h0,      1, 3, 2'b01, 0, 32'h1234F00D, 0, 1, 4'b1111, 32'h0,        0, 32'h0000F00D, 1, 0, 0, 1);

        // Reset while an access is waiting: FSM must drop back to IDLE and the register clears.
        lat = 1000;
        pc_in = 32'h70; iw_in = 32'h0000A383; alu_in = 32'h400; wb_en_in = 1'b1;
        wb_reg_in = 5'd8; src_sel_in = 2'b01;
        @(negedge clk);
        check("wait_stall_first", stall_out, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_stall_held", stall_out, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle();
        lat = 0;
        @(negedge clk);
        check("rstwait_iw_out", iw_out, NOP_IW);
        check("rstwait_pc_out", pc_out, 32'd0);
        check("rstwait_wb_en", wb_en_out, 1'b0);
        check("rstwait_req_idle", dmem_req, 1'b0);
        check("rstwait_stall", stall_out, 1'b0);
        @(posedge clk); #1;

        issue(32'h74, 32'h0000A383, 32'h404, 32'h0, 1, 4, 2'b01, 0, 32'h0BADF00D, 0, 1, 4'b1111, 32'h0, 0, 32'h0BADF00D, 1, 0, 0, 1);

`ifdef RV32I_MEM_TIMEOUT_EN
        issue(32'h78, 32'h0000A383, 32'h500, 32'h0, 1, 4, 2'b01, 1000, 32'h0, 4, 1, 4'b1111, 32'h0, 0, 32'h0, 0, 0, 1, 1);
        lat = 0;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
